bin2bcd_seq: RTL and testbench

- Sequential double-dabble (shift-add-3) converter: turns an unsigned binary value into DIGITS packed BCD nibbles.
- Sits directly upstream of the per-digit 7-segment decoders. Each output nibble drives one decoder's 4-bit input.
- Used to show audio-path numbers (frequency index, volume) on the HEX displays.
- One conversion per start request; the result is held stable between conversions.

---
 rtl/bin2bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, add-3 adjust constants and the counter width helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Bits needed to hold a shift count from WIDTH down to 0.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble cell: a BCD nibble of 5 or more gets +3
// before the next left shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Optional leading-zero blank mask: define BIN2BCD_LEADING_ZERO_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned BW = 4 * DIGITS;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    shift_reg, shift_nxt;
    logic [BW-1:0]       work_bcd, work_nxt, adj_bcd, bcd_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic                acc, acc_nxt;
    logic                busy_nxt, done_nxt, ovf_nxt;
    logic [BW+WIDTH:0]   shifted;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work_bcd[4*k +: 4]),
            .dout (adj_bcd[4*k +: 4])
        );
    end

    always_comb begin
        // Bit BW+WIDTH catches whatever falls off the top digit: any such bit
        // means the value needs more digits than we have.
        shifted   = {1'b0, adj_bcd, shift_reg} << 1;
        state_nxt = state;
        shift_nxt = shift_reg;
        work_nxt  = work_bcd;
        count_nxt = count;
        acc_nxt   = acc;
        bcd_nxt   = bcd;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    shift_nxt = bin;
                    work_nxt  = '0;
                    acc_nxt   = 1'b0;
                    count_nxt = CW'(WIDTH);
                end
            end
            SHIFT: begin
                shift_nxt = shifted[WIDTH-1:0];
                work_nxt  = shifted[BW+WIDTH-1:WIDTH];
                acc_nxt   = acc | shifted[BW+WIDTH];
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bcd_nxt   = work_bcd;
                ovf_nxt   = acc;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            shift_reg <= '0;
            work_bcd  <= '0;
            count     <= '0;
            acc       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            work_bcd  <= work_nxt;
            count     <= count_nxt;
            acc       <= acc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            bcd       <= bcd_nxt;
            ovf       <= ovf_nxt;
        end
    end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_nxt;
    logic              zero_above;

    // Walk down from the top digit; a digit blanks only while everything above
    // it is zero too. The units digit is always shown.
    always_comb begin
        blank_nxt  = blank_q;
        zero_above = 1'b1;
        if (state == DONE) begin
            blank_nxt = '0;
            for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
                zero_above   = zero_above & (work_bcd[4*k +: 4] == 4'd0);
                blank_nxt[k] = zero_above & ~acc;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_nxt;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit
// instance, with expected results queued at start and checked on done.
module tb_bin2bcd_seq;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin1 = '0, bin2 = '0;
    logic        busy1, done1, ovf1;
    logic [11:0] bcd1;
    logic [2:0]  blank1;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int ntests = 0;
    int nfail  = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    exp_t sb[$];

    logic        cur_sel = 1'b0;
    logic        obs_done, obs_busy, obs_ovf;
    logic [11:0] obs_bcd;
    logic [2:0]  obs_blank;

    assign obs_done  = cur_sel ? done2 : done1;
    assign obs_busy  = cur_sel ? busy2 : busy1;
    assign obs_ovf   = cur_sel ? ovf2  : ovf1;
    assign obs_bcd   = cur_sel ? {4'h0, bcd2} : bcd1;
    assign obs_blank = cur_sel ? {1'b0, blank2} : blank1;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk), .clrn (clrn), .start (start1), .bin (bin1),
        .busy (busy1), .done (done1), .bcd (bcd1), .ovf (ovf1), .blank (blank1)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk (clk), .clrn (clrn), .start (start2), .bin (bin2),
        .busy (busy2), .done (done2), .bcd (bcd2), .ovf (ovf2), .blank (blank2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] v, input int unsigned nd);
        exp_t        e;
        int unsigned r, maxv;
        bit          all_zero;
        maxv = 1;
        for (int i = 0; i < int'(nd); i++) maxv *= 10;
        e.bcd   = '0;
        e.blank = '0;
        e.ovf   = (32'(v) >= maxv);
        r = 32'(v) % maxv;
        for (int i = 0; i < int'(nd); i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        all_zero = 1'b1;
        for (int i = int'(nd) - 1; i >= 1; i--) begin
            all_zero   = all_zero & (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = all_zero & ~e.ovf;
        end
`else
        all_zero = 1'b0;
`endif
        return e;
    endfunction

    // One start pulse, then wait (bounded) for done and score the result.
    // extra=1 fires a second start with a new bin three cycles in.
    task automatic convert(input logic sel, input logic [7:0] v, input bit extra);
        exp_t e, got;
        int   j;
        cur_sel = sel;
        @(negedge clk);
        if (sel) begin bin2 = v; start2 = 1'b1; end
        else     begin bin1 = v; start1 = 1'b1; end
        e = model(v, sel ? 2 : 3);
        sb.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        j = 0;
        while (!obs_done && j < 20) begin
            check("busy_high", 32'(obs_busy), 32'd1);
            if (extra && j == 3) begin bin1 = 8'd77; start1 = 1'b1; end
            if (extra && j == 4) start1 = 1'b0;
            @(negedge clk);
            j++;
        end
        check("done_seen", 32'(obs_done), 32'd1);
        if (obs_done) begin
            check("latency", 32'(j), 32'd9);
            check("busy_low_at_done", 32'(obs_busy), 32'd0);
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                got = sb.pop_front();
                check("bcd", 32'(obs_bcd), 32'(got.bcd));
                check("ovf", 32'(obs_ovf), 32'(got.ovf));
                check("blank", 32'(obs_blank), 32'(got.blank));
            end
            @(negedge clk);
            check("done_one_cycle", 32'(obs_done), 32'd0);
        end
    endtask

    initial begin
        int before1, before2;

        #2 clrn = 1'b0;
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_bcd", 32'(bcd1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_blank", 32'(blank1), 32'd0);
        check("rst_bcd2", 32'(bcd2), 32'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        convert(1'b0, 8'd255, 1'b0);
        convert(1'b0, 8'd0,   1'b0);
        convert(1'b0, 8'd9,   1'b0);

        convert(1'b0, 8'd128, 1'b1);
        #1 before1 = done_cnt1;
        repeat (12) @(negedge clk);
        #1;
        check("dropped_start_no_done", 32'(done_cnt1 - before1), 32'd0);
        check("dropped_start_bcd_held", 32'(bcd1), 32'h128);

        convert(1'b1, 8'd200, 1'b0);
        convert(1'b1, 8'd42,  1'b0);
        convert(1'b1, 8'd99,  1'b0);

        convert(1'b0, 8'd7,   1'b0);
        convert(1'b0, 8'd0,   1'b0);
        convert(1'b0, 8'd105, 1'b0);

        // Leave non-zero outputs on both instances before the abort.
        convert(1'b1, 8'd200, 1'b0);
        convert(1'b0, 8'd42,  1'b0);

        cur_sel = 1'b0;
        @(negedge clk);
        bin1 = 8'd255;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        #1 before1 = done_cnt1;
        before2 = done_cnt2;
        clrn = 1'b0;
        #1;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_done", 32'(done1), 32'd0);
        check("abort_bcd", 32'(bcd1), 32'd0);
        check("abort_ovf", 32'(ovf1), 32'd0);
        check("abort_blank", 32'(blank1), 32'd0);
        check("abort_bcd2", 32'(bcd2), 32'd0);
        check("abort_ovf2", 32'(ovf2), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt1 - before1), 32'd0);
        check("abort_no_done2", 32'(done_cnt2 - before2), 32'd0);
        check("abort_bcd_still_zero", 32'(bcd1), 32'd0);

        convert(1'b0, 8'd255, 1'b0);
        convert(1'b1, 8'd42,  1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
